dut_result_checker: RTL and testbench
=====================================

# dut_result_checker

Streaming checker placed directly downstream of the combinational `dut` netlist (20-bit `in`, 10-bit `out`). Each cycle it accepts one stimulus vector together with the `dut` output for that vector and the golden output from the unoptimized netlist, and compares the two outputs. It counts vectors and mismatches, records the index of the first failure, and queues full mismatch records in a small FIFO for readout. A run ends on a flagged last vector, leaving a sticky pass/fail verdict. This replaces the one-shot file-based bench with a cycle-driven regression harness.

## Interface
- `IN_W`, 20, stimulus vector width (matches `dut.in`)
- `OUT_W`, 10, result width (matches `dut.out`)
- `DEPTH`, 4, mismatch-log FIFO entries (power of two, ≥2)
- `CNT_W`, 16, width of vector and error counters
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse; clears counters and log, begins a run
- `vec_valid`  in  1  stimulus/result pair presented
- `vec_ready`  out  1  checker accepts the pair this cycle
- `vec_last`  in  1  qualifies the final pair of the run (sampled with `vec_valid`)
- `vec_in`  in  IN_W  stimulus vector driven into `dut`
- `dut_out`  in  OUT_W  `dut` response to `vec_in`
- `gold_out`  in  OUT_W  golden response to `vec_in`
- `log_valid`  out  1  mismatch record available
- `log_ready`  in  1  consumer pops the record
- `log_data`  out  IN_W+2*OUT_W  record `{vec_in, dut_out, gold_out}`, MSB first
- `vec_count`  out  CNT_W  pairs accepted this run
- `err_count`  out  CNT_W  mismatching pairs this run
- `first_err_valid`  out  1  at least one mismatch seen this run
- `first_err_idx`  out  CNT_W  0-based index of the first mismatch
- `done`  out  1  run complete (sticky)
- `pass`  out  1  `done` and `err_count == 0`

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE: `start` → RUN. `vec_ready` is 0.
- RUN: `vec_ready = !fifo_full`. Accept = `vec_valid && vec_ready`. An accept with `vec_last` = 1 → DONE. `start` in RUN is ignored.
- DONE: `done` = 1. `vec_ready` is 0. `start` → RUN (new run).
- `start` accepted in IDLE or DONE clears `vec_count`, `err_count`, `first_err_valid`, `first_err_idx`, and the FIFO (pointers reset; `log_valid` drops next cycle).
- On accept:
  - `vec_count` increments.
  - If `dut_out != gold_out` (full-width compare):
    - `err_count` increments.
    - The record is pushed to the FIFO.
    - If `first_err_valid` = 0, it is set and `first_err_idx` takes the pre-increment `vec_count`.
- Both counters saturate at all-ones; no wrap.
- FIFO: first-word-fall-through. `log_data` is the head entry and is valid whenever `log_valid` = 1. Pop = `log_valid && log_ready`. Push and pop in the same cycle are both honoured; occupancy is unchanged.
- Full FIFO deasserts `vec_ready`, so no mismatch record is ever dropped. A pop in a full cycle frees space from the next cycle on.
- After DONE the FIFO still drains normally. `pass` does not depend on FIFO occupancy.
- Reset outputs: `vec_ready` 0, `log_valid` 0, `log_data` 0, all counters 0, `first_err_valid` 0, `first_err_idx` 0, `done` 0, `pass` 0.

## Timing
- `vec_ready` is a function of registered state and FIFO occupancy only. It has no combinational path from `vec_valid`, `log_ready` or `start`.
- Accept at edge N: counters, `first_err_*` and FIFO push are visible after edge N. A mismatch into an empty FIFO gives `log_valid` = 1 in cycle N+1.
- `vec_last` accept at edge N: `done` = 1 and `vec_ready` = 0 from cycle N+1. `pass` is valid in the same cycle as `done`.
- `start` at edge N (IDLE/DONE): RUN, cleared counters, and `vec_ready` = 1 (FIFO now empty) from cycle N+1.
- `rst` has priority over every other input. Reset mid-run discards in-flight state and FIFO contents.
- Throughput: one pair per cycle while the FIFO is not full.

## Test plan
- Reset then `start`: 3 pairs with matching outputs, last flagged → `vec_count`=3, `err_count`=0, `done`=1, `pass`=1, `log_valid` never asserted.
- Single mismatch at index 2 (`vec_in`=20'h0F0F0, `dut_out`=10'h211, `gold_out`=10'h210) → `err_count`=1, `first_err_idx`=2, `log_data`=={20'h0F0F0,10'h211,10'h210} one cycle after the accept, `pass`=0.
- Back-to-back mismatches, `log_ready`=0 → `vec_ready` drops after the 4th push. Raise `log_ready` for one pop → exactly one more pair accepted. All 5 records are read in order.
- Simultaneous push and pop with FIFO at 2 entries → occupancy stays 2 and record order is preserved.
- Assert `rst` mid-run with 3 logged errors → next cycle all outputs at reset values, state IDLE. A fresh `start` run behaves as if from power-up.
- Second `start` from DONE after a failing run → counters and log cleared, `done`=0, a new all-match run ends `pass`=1.

Source files
------------

// File: rtl/dut_result_checker_if.sv
// Handshake bundle between the stimulus source and the result checker:
// the stimulus/result stream in, the mismatch-record stream out.
interface dut_result_checker_if #(
    parameter int IN_W  = 20,
    parameter int OUT_W = 10
);
    // Stimulus/result stream
    logic                      vec_valid;
    logic                      vec_ready;
    logic                      vec_last;
    logic [IN_W-1:0]           vec_in;
    logic [OUT_W-1:0]          dut_out;
    logic [OUT_W-1:0]          gold_out;

    // Mismatch-record stream
    logic                      log_valid;
    logic                      log_ready;
    logic [IN_W+2*OUT_W-1:0]   log_data;

    // Stimulus source / log consumer side
    modport master (
        output vec_valid, vec_last, vec_in, dut_out, gold_out, log_ready,
        input  vec_ready, log_valid, log_data
    );

    // Checker side
    modport slave (
        input  vec_valid, vec_last, vec_in, dut_out, gold_out, log_ready,
        output vec_ready, log_valid, log_data
    );
endinterface

// File: rtl/dut_result_checker.sv
// Streaming result checker: compares dut_out against gold_out for each
// accepted vector, counts vectors and mismatches, remembers the first
// failing index, and queues full mismatch records in a small FWFT FIFO.
// A flagged last vector ends the run with a sticky pass/fail verdict.
module dut_result_checker #(
    parameter int IN_W  = 20,
    parameter int OUT_W = 10,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    dut_result_checker_if.slave   bus,
    output logic [CNT_W-1:0]      vec_count,
    output logic [CNT_W-1:0]      err_count,
    output logic                  first_err_valid,
    output logic [CNT_W-1:0]      first_err_idx,
    output logic                  done,
    output logic                  pass
);

    localparam int REC_W = IN_W + 2 * OUT_W;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    // Log FIFO storage; pointers carry one extra wrap bit so full and
    // empty are distinguishable without a separate counter.
    logic [REC_W-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [AW:0]      occupancy;
    logic             fifo_full, fifo_empty;

    logic             clear;     // start accepted outside a run
    logic             accept;
    logic             mismatch;
    logic             push, pop;

    assign occupancy  = wr_ptr - rd_ptr;
    assign fifo_full  = (occupancy == (AW+1)'(DEPTH));
    assign fifo_empty = (occupancy == '0);

    assign mismatch = (bus.dut_out != bus.gold_out);
    assign accept   = bus.vec_valid && bus.vec_ready;
    assign push     = accept && mismatch;
    assign pop      = !fifo_empty && bus.log_ready;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and run-control decode; vec_ready depends only on state
    // and FIFO occupancy.
    always_comb begin
        // NOTE: every output of this block gets a default first so no
        // path through the case leaves a value held, which would be a latch.
        state_d       = state_q;
        clear         = 1'b0;
        bus.vec_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    clear   = 1'b1;
                end
            end
            S_RUN: begin
                bus.vec_ready = !fifo_full;
                if (bus.vec_valid && !fifo_full && bus.vec_last) state_d = S_DONE;
            end
            S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    clear   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Vector/error counters and first-failure capture, saturating.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            vec_count       <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
        end else if (accept) begin
            if (vec_count != '1) vec_count <= vec_count + 1'b1;
            if (mismatch) begin
                if (err_count != '1) err_count <= err_count + 1'b1;
                if (!first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_idx   <= vec_count;
                end
            end
        end
    end

    // FIFO pointers; a run start or reset empties the log.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO storage write.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; the pointers define which
        // entries are meaningful and log_data is masked while empty.
        if (push) mem[wr_ptr[AW-1:0]] <= {bus.vec_in, bus.dut_out, bus.gold_out};
    end

    assign bus.log_valid = !fifo_empty;
    assign bus.log_data  = fifo_empty ? '0 : mem[rd_ptr[AW-1:0]];

    assign done = (state_q == S_DONE);
    assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_dut_result_checker.sv
// Directed-plus-random bench for dut_result_checker. A cycle-level model
// (integer counters plus a queue of expected records) predicts every
// observable output; all outputs are compared on the falling edge.
module tb_dut_result_checker;

    localparam int IN_W  = 20;
    localparam int OUT_W = 10;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
    localparam int REC_W = IN_W + 2 * OUT_W;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [CNT_W-1:0] vec_count, err_count, first_err_idx;
    logic             first_err_valid, done, pass;

    dut_result_checker_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    dut_result_checker #(
        .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .bus             (bus.slave),
        .vec_count       (vec_count),
        .err_count       (err_count),
        .first_err_valid (first_err_valid),
        .first_err_idx   (first_err_idx),
        .done            (done),
        .pass            (pass)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit               m_run, m_done, m_fv;
    int               m_vec, m_err, m_fidx;
    logic [REC_W-1:0] m_log [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [REC_W-1:0] head;
        head = (m_log.size() > 0) ? m_log[0] : '0;
        check("vec_ready",       64'(bus.vec_ready),   64'(m_run && m_log.size() < DEPTH));
        check("log_valid",       64'(bus.log_valid),   64'(m_log.size() > 0));
        check("log_data",        64'(bus.log_data),    64'(head));
        check("vec_count",       64'(vec_count),       64'(m_vec));
        check("err_count",       64'(err_count),       64'(m_err));
        check("first_err_valid", 64'(first_err_valid), 64'(m_fv));
        check("first_err_idx",   64'(first_err_idx),   64'(m_fidx));
        check("done",            64'(done),            64'(m_done));
        check("pass",            64'(pass),            64'(m_done && m_err == 0));
    endtask

    task automatic model_clear();
        m_vec  = 0;
        m_err  = 0;
        m_fv   = 1'b0;
        m_fidx = 0;
        m_log.delete();
    endtask

    // One clock cycle: drive inputs, let the edge happen, advance the
    // model, then compare everything on the falling edge.
    task automatic step(input bit v, input logic [IN_W-1:0] vi, input logic [OUT_W-1:0] d,
                        input logic [OUT_W-1:0] g, input bit last, input bit lr,
                        input bit st, input bit rs);
        bit acc, pp;
        bus.vec_valid = v;
        bus.vec_in    = vi;
        bus.dut_out   = d;
        bus.gold_out  = g;
        bus.vec_last  = last;
        bus.log_ready = lr;
        start         = st;
        rst           = rs;
        acc = v && m_run && (m_log.size() < DEPTH);
        pp  = lr && (m_log.size() > 0);
        @(posedge clk);
        if (rs) begin
            model_clear();
            m_run  = 1'b0;
            m_done = 1'b0;
        end else if (st && !m_run) begin
            model_clear();
            m_run  = 1'b1;
            m_done = 1'b0;
        end else begin
            if (pp) void'(m_log.pop_front());
            if (acc) begin
                if (d != g) begin
                    if (!m_fv) begin
                        m_fv   = 1'b1;
                        m_fidx = m_vec;
                    end
                    if (m_err < CMAX) m_err++;
                    m_log.push_back({vi, d, g});
                end
                if (m_vec < CMAX) m_vec++;
                if (last) begin
                    m_run  = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
        @(negedge clk);
        bus.vec_valid = 1'b0;
        bus.log_ready = 1'b0;
        start         = 1'b0;
        rst           = 1'b0;
        check_all();
    endtask

    task automatic idle(input int n, input bit lr);
        for (int i = 0; i < n; i++) step(0, '0, '0, '0, 0, lr, 0, 0);
    endtask

    task automatic do_start();
        step(0, '0, '0, '0, 0, 0, 1, 0);
    endtask

    task automatic send(input bit miss, input bit last, input bit lr);
        logic [IN_W-1:0]  vi;
        logic [OUT_W-1:0] g, d;
        vi = IN_W'($urandom);
        g  = OUT_W'($urandom);
        d  = miss ? (g ^ OUT_W'($urandom_range(1, (1 << OUT_W) - 1))) : g;
        step(1, vi, d, g, last, lr, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IN_W-1:0]  vi5;
        logic [OUT_W-1:0] g5, d5;
        int               n;

        bus.vec_valid = 1'b0;
        bus.vec_last  = 1'b0;
        bus.vec_in    = '0;
        bus.dut_out   = '0;
        bus.gold_out  = '0;
        bus.log_ready = 1'b0;
        start         = 1'b0;
        rst           = 1'b1;
        m_run         = 1'b0;
        m_done        = 1'b0;
        model_clear();

        // Reset state
        step(0, '0, '0, '0, 0, 0, 0, 1);
        step(0, '0, '0, '0, 0, 0, 0, 1);
        idle(1, 0);

        // All-match run of three pairs; a start mid-run is ignored
        do_start();
        send(0, 0, 0);
        step(0, '0, '0, '0, 0, 0, 1, 0);
        send(0, 0, 0);
        send(0, 1, 0);
        check("t1_vec_count", 64'(vec_count), 64'd3);
        check("t1_pass", 64'(pass), 64'd1);
        idle(2, 0);

        // Single mismatch at index 2
        do_start();
        send(0, 0, 0);
        send(0, 0, 0);
        step(1, 20'h0F0F0, 10'h211, 10'h210, 0, 0, 0, 0);
        check("t2_log_data", 64'(bus.log_data), 64'({20'h0F0F0, 10'h211, 10'h210}));
        check("t2_first_idx", 64'(first_err_idx), 64'd2);
        send(0, 1, 0);
        check("t2_pass", 64'(pass), 64'd0);
        idle(2, 1);

        // Back-to-back mismatches fill the log and stall the stream
        do_start();
        for (int i = 0; i < 4; i++) send(1, 0, 0);
        vi5 = IN_W'($urandom);
        g5  = OUT_W'($urandom);
        d5  = ~g5;
        step(1, vi5, d5, g5, 1, 0, 0, 0);
        check("t3_stalled_count", 64'(vec_count), 64'd4);
        step(1, vi5, d5, g5, 1, 1, 0, 0);
        step(1, vi5, d5, g5, 1, 0, 0, 0);
        check("t3_fifth_count", 64'(vec_count), 64'd5);
        send(1, 1, 0);
        check("t3_no_sixth", 64'(vec_count), 64'd5);
        idle(6, 1);

        // Simultaneous push and pop at two entries
        do_start();
        send(1, 0, 0);
        send(1, 0, 0);
        send(1, 0, 1);
        send(0, 0, 0);
        idle(3, 1);
        send(0, 1, 0);

        // Reset mid-run with three logged errors, then a fresh run
        do_start();
        for (int i = 0; i < 3; i++) send(1, 0, 0);
        step(0, '0, '0, '0, 0, 0, 0, 1);
        idle(1, 0);
        do_start();
        send(0, 0, 0);
        send(0, 1, 0);
        check("t5_pass", 64'(pass), 64'd1);

        // Failing run, then restart from DONE with an all-match run
        do_start();
        send(1, 0, 0);
        send(0, 1, 0);
        check("t6_fail", 64'(pass), 64'd0);
        do_start();
        send(0, 0, 0);
        send(0, 0, 0);
        send(0, 1, 0);
        check("t6_pass", 64'(pass), 64'd1);

        // Randomised run with random log back-pressure
        do_start();
        n = 0;
        while (!m_done && n < 200) begin
            send($urandom_range(0, 3) == 0, n >= 30, $urandom_range(0, 1) == 1);
            n++;
        end
        check("rand_done", 64'(done), 64'd1);
        idle(8, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
